calc1_req_agent: RTL and testbench

- Synthesizable initiator for one calc1 request port. Drives the same cmd/data/resp protocol that the calc1 benches drive by hand.
- Accepts one operation (op, operand1, operand2) from a host valid/ready interface and serializes it onto req_cmd/req_data over two cycles.
- Waits for the calc1 response, then returns resp/data to the host.
- Sits between on-chip control logic and one calc1 port. Four instances cover all four ports.

---
 rtl/calc1_req_agent.sv | 141 ++++++++++++++
 tb/tb_calc1_req_agent.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/calc1_req_agent.sv
// Request agent for one calc1 port: takes a host op, sends op1/op2 over two cycles, returns the response.
// Optional build macro CALC1_REQ_CMD_CHECK_EN: only add/sub/shl/shr are forwarded, others fail locally.
module calc1_req_agent #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [3:0]  host_op,
    input  logic [0:31] host_a,
    input  logic [0:31] host_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_resp,
    output logic [0:31] rsp_data,
    output logic [3:0]  req_cmd,
    output logic [0:31] req_data,
    input  logic [1:0]  out_resp,
    input  logic [0:31] out_data
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_OP1  = 3'd1,
        SEND_OP2  = 3'd2,
        WAIT_RESP = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state, state_nx;
    logic [0:31]       b_q, b_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [3:0]        cmd_nx;
    logic [0:31]       data_nx;
    logic              vld_nx;
    logic [1:0]        resp_nx;
    logic [0:31]       rdata_nx;
    logic              op_fwd;

    always_comb begin
`ifdef CALC1_REQ_CMD_CHECK_EN
        op_fwd = (host_op == 4'd1) || (host_op == 4'd2) ||
                 (host_op == 4'd5) || (host_op == 4'd6);
`else
        op_fwd = (host_op != 4'd0);
`endif
    end

    assign host_ready = (state == IDLE);

    always_comb begin
        state_nx = state;
        b_nx     = b_q;
        cnt_nx   = cnt;
        cmd_nx   = req_cmd;
        data_nx  = req_data;
        vld_nx   = rsp_valid;
        resp_nx  = rsp_resp;
        rdata_nx = rsp_data;
        case (state)
            IDLE: begin
                if (host_valid) begin
                    if (op_fwd) begin
                        // op/a go straight onto the bus; only b needs holding for the second beat
                        state_nx = SEND_OP1;
                        cmd_nx   = host_op;
                        data_nx  = host_a;
                        b_nx     = host_b;
                    end else begin
                        state_nx = DONE;
                        vld_nx   = 1'b1;
                        resp_nx  = 2'd2;
                        rdata_nx = '0;
                    end
                end
            end
            SEND_OP1: begin
                state_nx = SEND_OP2;
                cmd_nx   = 4'd0;
                data_nx  = b_q;
            end
            SEND_OP2: begin
                state_nx = WAIT_RESP;
                data_nx  = '0;
                cnt_nx   = CNT_W'(1);
            end
            WAIT_RESP: begin
                // a real response beats a timeout landing in the same cycle
                if (out_resp != 2'd0) begin
                    state_nx = DONE;
                    vld_nx   = 1'b1;
                    resp_nx  = out_resp;
                    rdata_nx = out_data;
                end else if (cnt >= TO_LIMIT) begin
                    state_nx = DONE;
                    vld_nx   = 1'b1;
                    resp_nx  = 2'd3;
                    rdata_nx = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                    vld_nx   = 1'b0;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state     <= IDLE;
            b_q       <= '0;
            cnt       <= '0;
            req_cmd   <= '0;
            req_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_resp  <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nx;
            b_q       <= b_nx;
            cnt       <= cnt_nx;
            req_cmd   <= cmd_nx;
            req_data  <= data_nx;
            rsp_valid <= vld_nx;
            rsp_resp  <= resp_nx;
            rsp_data  <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_calc1_req_agent.sv
// Bench for calc1_req_agent: directed + random ops against a calc1 stub and an arithmetic reference.
module tb_calc1_req_agent;
    localparam int TO = 8;

    logic        c_clk = 1'b0;
    logic        reset, host_valid, rsp_ready;
    logic [3:0]  host_op;
    logic [31:0] host_a, host_b;
    logic        host_ready, rsp_valid;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [3:0]  req_cmd;
    logic [31:0] req_data;
    logic [1:0]  out_resp;
    logic [31:0] out_data;

    int tests = 0;
    int fails = 0;
    bit resp_en;
    int resp_lat;

    always #5 c_clk = ~c_clk;

    calc1_req_agent #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .c_clk(c_clk), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_op(host_op), .host_a(host_a), .host_b(host_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_resp(rsp_resp), .rsp_data(rsp_data),
        .req_cmd(req_cmd), .req_data(req_data),
        .out_resp(out_resp), .out_data(out_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // calc1 arithmetic: {resp, data}
    function automatic logic [33:0] calc_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] s;
        case (op)
            4'd1: begin
                s = 64'(a) + 64'(b);
                return (s > 64'h0000_0000_FFFF_FFFF) ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            end
            4'd2: return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5: return {2'd1, a << b[4:0]};
            4'd6: return {2'd1, a >> b[4:0]};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    function automatic bit forwarded(input logic [3:0] op);
`ifdef CALC1_REQ_CMD_CHECK_EN
        return (op == 4'd1) || (op == 4'd2) || (op == 4'd5) || (op == 4'd6);
`else
        return op != 4'd0;
`endif
    endfunction

    // calc1 port stub: reads two beats off the bus, answers after resp_lat cycles
    initial begin : calc1_stub
        logic [3:0]  c;
        logic [31:0] ra, rb;
        logic [33:0] r;
        out_resp = 2'd0;
        out_data = 32'hA5A5_A5A5;
        forever begin
            @(negedge c_clk);
            if (resp_en && req_cmd != 4'd0) begin
                c  = req_cmd;
                ra = req_data;
                @(negedge c_clk);
                rb = req_data;
                r  = calc_ref(c, ra, rb);
                repeat (resp_lat) @(negedge c_clk);
                out_resp = r[33:32];
                out_data = r[31:0];
                @(negedge c_clk);
                out_resp = 2'd0;
                out_data = 32'hA5A5_A5A5;
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int hold);
        logic [33:0] exp;
        int n;
        exp = forwarded(op) ? calc_ref(op, a, b) : {2'd2, 32'd0};
        resp_lat = lat;
        check("idle_ready", host_ready, 1);
        host_valid = 1'b1; host_op = op; host_a = a; host_b = b;
        @(negedge c_clk);
        host_valid = 1'b0; host_op = 4'($urandom); host_a = $urandom; host_b = $urandom;
        if (forwarded(op)) begin
            check("op1_cmd", req_cmd, op);
            check("op1_data", req_data, a);
            check("busy_ready", host_ready, 0);
            @(negedge c_clk);
            check("op2_cmd", req_cmd, 0);
            check("op2_data", req_data, b);
            n = 0;
            while (!rsp_valid && n < 100) begin
                @(negedge c_clk);
                n++;
            end
            check("latency", n, lat + 1);
        end else begin
            check("local_cmd", req_cmd, 0);
            check("local_vld", rsp_valid, 1);
        end
        check("resp", rsp_resp, exp[33:32]);
        check("data", rsp_data, exp[31:0]);
        repeat (hold) begin
            @(negedge c_clk);
            check("hold_vld", rsp_valid, 1);
            check("hold_resp", rsp_resp, exp[33:32]);
            check("hold_data", rsp_data, exp[31:0]);
            check("hold_ready", host_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge c_clk);
        rsp_ready = 1'b0;
        check("vld_clear", rsp_valid, 0);
        check("ready_back", host_ready, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [3:0] optab [8];
        int n;
        bit seen;
        logic [31:0] ra, rb;
        optab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd4, 4'd15};

        reset = 1'b1; host_valid = 1'b0; rsp_ready = 1'b0;
        host_op = 4'd0; host_a = '0; host_b = '0;
        resp_en = 1'b1; resp_lat = 1;
        repeat (2) @(negedge c_clk);
        reset = 1'b0;
        @(negedge c_clk);
        check("rst_ready", host_ready, 1);
        check("rst_vld", rsp_valid, 0);
        check("rst_cmd", req_cmd, 0);
        check("rst_rdata", req_data, 0);
        check("rst_resp", rsp_resp, 0);
        check("rst_data", rsp_data, 0);

        run_op(4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2, 0);
        run_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0);
        run_op(4'd2, 32'h0000_0001, 32'h0000_000F, 3, 0);
        run_op(4'd1, 32'h0, 32'h0, 1, 0);
        run_op(4'd3, 32'h1, 32'h0, 2, 0);
        run_op(4'd0, 32'h1234, 32'h5678, 1, 0);
        run_op(4'd1, 32'd5, 32'd7, 2, 5);

        // timeout: no calc1 answer
        resp_en = 1'b0;
        host_valid = 1'b1; host_op = 4'd1; host_a = 32'd1; host_b = 32'd2;
        @(negedge c_clk);
        host_valid = 1'b0;
        @(negedge c_clk);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge c_clk);
            n++;
        end
        check("to_latency", n, TO + 1);
        check("to_resp", rsp_resp, 3);
        check("to_data", rsp_data, 0);
        rsp_ready = 1'b1;
        @(negedge c_clk);
        rsp_ready = 1'b0;
        check("to_ready_back", host_ready, 1);

        // reset while waiting; the stub answers after reset and must be ignored
        resp_en = 1'b1; resp_lat = 4;
        host_valid = 1'b1; host_op = 4'd1; host_a = 32'd1; host_b = 32'd1;
        @(negedge c_clk);
        host_valid = 1'b0;
        repeat (3) @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
        reset = 1'b0;
        check("mid_rst_ready", host_ready, 1);
        check("mid_rst_vld", rsp_valid, 0);
        check("mid_rst_cmd", req_cmd, 0);
        check("mid_rst_rdata", req_data, 0);
        check("mid_rst_resp", rsp_resp, 0);
        check("mid_rst_data", rsp_data, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge c_clk);
            seen = seen | rsp_valid;
        end
        check("late_resp_ignored", seen, 0);
        run_op(4'd1, 32'd2, 32'd3, 1, 0);

        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op(optab[$urandom_range(0, 7)], ra, rb, $urandom_range(1, 4), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
